// File: rtl/can_pkg.sv
// can_pkg: register map, CTRL bit positions and the FIFO entry layout for the CAN receive FIFO.
package can_pkg;
    localparam logic [2:0] CAN_RF_CTRL       = 3'd0;
    localparam logic [2:0] CAN_RF_HEAD_ID    = 3'd1;
    localparam logic [2:0] CAN_RF_HEAD_INFO  = 3'd2;
    localparam logic [2:0] CAN_RF_HEAD_DATA0 = 3'd3;
    localparam logic [2:0] CAN_RF_HEAD_DATA1 = 3'd4;
    localparam logic [2:0] CAN_RF_FSEL       = 3'd5;
    localparam logic [2:0] CAN_RF_FKEY       = 3'd6;
    localparam logic [2:0] CAN_RF_FMASK      = 3'd7;

    localparam int CAN_CTRL_POP    = 8;
    localparam int CAN_CTRL_FLUSH  = 9;
    localparam int CAN_CTRL_OVFCLR = 10;

    localparam int CAN_ENTRY_W = 102;
    localparam logic [2:0] NO_FILTER_HIT = 3'd7;

    typedef struct packed {
        logic        ext;
        logic        rtr;
        logic [28:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [2:0]  hit;
    } can_entry_t;
endpackage

// File: rtl/can_acc_filter.sv
// can_acc_filter: key/mask acceptance bank with lowest-index-wins priority match, output {accept, hit}.
module can_acc_filter
    import can_pkg::*;
#(
    parameter int NFILT = 4,
    localparam int SW = (NFILT > 1) ? $clog2(NFILT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW-1:0]    i_sel,
    input  logic             i_key_we,
    input  logic             i_mask_we,
    input  logic             i_en_we,
    input  logic [29:0]      i_wdata,
    input  logic [NFILT-1:0] i_en,
    input  logic [29:0]      i_frm_key,
    output logic [29:0]      o_key,
    output logic [29:0]      o_mask,
    output logic [NFILT-1:0] o_en,
    output logic [3:0]       o_match
);
    logic [29:0]      r_key  [NFILT];
    logic [29:0]      r_mask [NFILT];
    logic [NFILT-1:0] r_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en <= '0;
            for (int i = 0; i < NFILT; i++) begin
                r_key[i]  <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            if (i_en_we) r_en <= i_en;
            if (i_key_we) r_key[i_sel] <= i_wdata;
            if (i_mask_we) r_mask[i_sel] <= i_wdata;
        end
    end

    // Scanning downwards lets the lowest-index hit overwrite any higher one.
    always_comb begin
        o_match = {(r_en == '0), NO_FILTER_HIT};
        for (int i = NFILT - 1; i >= 0; i--)
            if (r_en[i] && ((r_key[i] ^ i_frm_key) & r_mask[i]) == '0) o_match = {1'b1, 3'(i)};
    end

    assign o_key  = r_key[i_sel];
    assign o_mask = r_mask[i_sel];
    assign o_en   = r_en;
endmodule

// File: rtl/can_rx_fifo_filter.sv
// can_rx_fifo_filter: filters received CAN frames and buffers accepted ones in a FIFO read over the register bus.
module can_rx_fifo_filter
    import can_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NFILT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [2:0]  rs,
    input  logic [3:0]  bytesel,
    input  logic [31:0] d,
    output logic [31:0] q,
    input  logic        frm_valid,
    input  logic        frm_ext,
    input  logic        frm_rtr,
    input  logic [28:0] frm_id,
    input  logic [3:0]  frm_dlc,
    input  logic [63:0] frm_data,
    output logic        irq,
    output logic [4:0]  fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (NFILT > 1) ? $clog2(NFILT) : 1;
    localparam logic [3:0] NF = 4'(NFILT);

    can_entry_t    r_mem [DEPTH];
    can_entry_t    r_s1;
    logic          r_s1_valid;
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          r_ovf, r_irq;
    logic [3:0]    r_thresh;
    logic [1:0]    r_irqen;
    logic [2:0]    r_fsel;

    logic             w_wr, w_ctrl_wr, w_empty, w_full, w_pop, w_flush, w_ovfclr, w_push, w_ovf_ev;
    logic [4:0]       w_count5;
    can_entry_t       w_head;
    logic [29:0]      w_key, w_mask;
    logic [NFILT-1:0] w_en;
    logic [3:0]       w_match;

    assign w_wr      = cs && bytesel == 4'b1111;
    assign w_ctrl_wr = w_wr && rs == CAN_RF_CTRL;
    assign w_empty   = r_count == '0;
    assign w_full    = r_count == CW'(DEPTH);
    assign w_pop     = w_ctrl_wr && d[CAN_CTRL_POP] && !w_empty;
    assign w_flush   = w_ctrl_wr && d[CAN_CTRL_FLUSH];
    assign w_ovfclr  = w_ctrl_wr && d[CAN_CTRL_OVFCLR];
    // A same-cycle pop frees the slot before the push is judged.
    assign w_push    = r_s1_valid && !w_flush && (!w_full || w_pop);
    assign w_ovf_ev  = r_s1_valid && !w_flush && w_full && !w_pop;
    assign w_count5  = 5'(r_count);
    assign w_head    = w_empty ? '0 : r_mem[r_rp];

    can_acc_filter #(.NFILT(NFILT)) u_filt (
        .clk       (clk),
        .reset     (reset),
        .i_sel     (r_fsel[SW-1:0]),
        .i_key_we  (w_wr && rs == CAN_RF_FKEY),
        .i_mask_we (w_wr && rs == CAN_RF_FMASK),
        .i_en_we   (w_wr && rs == CAN_RF_FSEL),
        .i_wdata   (d[29:0]),
        .i_en      (d[8 +: NFILT]),
        .i_frm_key ({frm_ext, frm_id}),
        .o_key     (w_key),
        .o_mask    (w_mask),
        .o_en      (w_en),
        .o_match   (w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
            r_thresh   <= 4'd1;
            r_irqen    <= 2'd0;
            r_fsel     <= 3'd0;
        end else begin
            r_s1_valid <= frm_valid && w_match[3] && !w_flush;
            r_s1       <= '{frm_ext, frm_rtr, frm_id, frm_dlc, frm_data, w_match[2:0]};
            if (w_push) r_mem[r_wp] <= r_s1;
            if (w_flush) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_count <= '0;
            end else begin
                r_wp    <= r_wp + AW'(w_push);
                r_rp    <= r_rp + AW'(w_pop);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            if (w_ovf_ev) r_ovf <= 1'b1;
            else if (w_ovfclr) r_ovf <= 1'b0;
            if (w_ctrl_wr) begin
                r_thresh <= (d[19:16] == 4'd0) ? 4'd1 : d[19:16];
                r_irqen  <= d[25:24];
            end
            if (w_wr && rs == CAN_RF_FSEL) r_fsel <= ({1'b0, d[2:0]} >= NF) ? 3'd0 : d[2:0];
            r_irq <= (r_irqen[0] && w_count5 >= {1'b0, r_thresh} && !w_empty) || (r_irqen[1] && r_ovf);
        end
    end

    always_comb begin
        q = '0;
        if (cs)
            case (rs)
                CAN_RF_CTRL:       q = {6'b0, r_irqen, 4'b0, r_thresh, 8'b0, r_ovf, w_full, w_empty, w_count5};
                CAN_RF_HEAD_ID:    q = {w_head.ext, w_head.rtr, 1'b0, w_head.id};
                CAN_RF_HEAD_INFO:  q = {21'b0, w_head.hit, 4'b0, w_head.dlc};
                CAN_RF_HEAD_DATA0: q = w_head.data[31:0];
                CAN_RF_HEAD_DATA1: q = w_head.data[63:32];
                CAN_RF_FSEL:       q = 32'({w_en, 5'b0, r_fsel});
                CAN_RF_FKEY:       q = {2'b0, w_key};
                CAN_RF_FMASK:      q = {2'b0, w_mask};
                default:           q = '0;
            endcase
    end

    assign irq        = r_irq;
    assign fifo_count = w_count5;
endmodule
